// File: rtl/regfile_alu_datapath_pkg.sv
// Shared constants and types for the register-bank / ALU datapath and its controllers.
// Holds opcode encodings, register indices, the "no write" select code and the flag bundle.
// Pure declarations: no logic, no latency.
package regfile_alu_datapath_pkg;

  localparam int DATAWIDTH     = 8;
  localparam int SELECTIONALU  = 3;
  localparam int SELECTIONDECO = 3;

  // ALU opcodes (the controllers drive these on sSelAlu)
  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_SHL  = 3'b100;
  localparam logic [2:0] ALU_SHR  = 3'b101;
  localparam logic [2:0] ALU_OR   = 3'b110;
  localparam logic [2:0] ALU_XOR  = 3'b111;

  // Register indices and the write-select code that suppresses write-back
  localparam logic [2:0] REG_R0    = 3'd0;
  localparam logic [2:0] REG_RP0   = 3'd6;
  localparam logic [2:0] REG_RP1   = 3'd7;
  localparam logic [2:0] DECO_NONE = 3'b111;

  // Status flags returned to the controller
  typedef struct packed {
    logic overflow;
    logic carry;
    logic negative;
    logic zero;
    logic par;
  } flags_t;

endpackage

// File: rtl/regfile_alu_datapath_alu.sv
// Combinational ALU: opcode, A, B in; result and five status flags out.
// Zero latency; sits between the operand registers and the result register.
// No handshake: evaluates every cycle whatever the controller drives.
module datapath_alu
  import regfile_alu_datapath_pkg::*;
#(
  parameter int DW = DATAWIDTH,
  parameter int SW = SELECTIONALU
) (
  input  logic [SW-1:0] op_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output logic [DW-1:0] res_o,
  output flags_t        flags_o
);

  // One extra bit holds carry-out for add and the borrow for subtract
  logic [DW:0]   sum;
  logic [DW-1:0] res;
  logic          carry;
  logic          ovf;

  // Opcode decode: result plus the op-specific carry/overflow meaning
  always_comb begin
    sum   = '0;
    res   = a_i;
    carry = 1'b0;
    ovf   = 1'b0;
    case (op_i)
      ALU_PASS: res = a_i;
      ALU_ADD: begin
        sum   = {1'b0, a_i} + {1'b0, b_i};
        res   = sum[DW-1:0];
        carry = sum[DW];
        // Same-sign operands producing a result of the other sign
        ovf   = (a_i[DW-1] == b_i[DW-1]) && (res[DW-1] != a_i[DW-1]);
      end
      ALU_SUB: begin
        sum   = {1'b0, a_i} - {1'b0, b_i};
        res   = sum[DW-1:0];
        // Top bit of the widened difference is set exactly when A < B unsigned
        carry = sum[DW];
        ovf   = (a_i[DW-1] != b_i[DW-1]) && (res[DW-1] != a_i[DW-1]);
      end
      ALU_AND: res = a_i & b_i;
      ALU_SHL: begin
        res   = {a_i[DW-2:0], 1'b0};
        carry = a_i[DW-1];
        // Sign changes when the two top bits differ
        ovf   = a_i[DW-1] ^ a_i[DW-2];
      end
      ALU_SHR: begin
        res   = {1'b0, a_i[DW-1:1]};
        carry = a_i[0];
      end
      ALU_OR:  res = a_i | b_i;
      ALU_XOR: res = a_i ^ b_i;
      default: res = a_i;
    endcase
  end

  // Result-derived flags are common to every opcode
  always_comb begin
    res_o            = res;
    flags_o.overflow = ovf;
    flags_o.carry    = carry;
    flags_o.negative = res[DW-1];
    flags_o.zero     = (res == '0);
    flags_o.par      = ^res;
  end

endmodule

// File: rtl/regfile_alu_datapath.sv
// Eight-entry register bank with two read ports, one ALU and one write-back port.
// Latency: operands read at edge T, result/flags registered at T+1, written back at T+2.
// No backpressure: the controller owns hazard spacing; reads never bypass writes.
module regfile_alu_datapath
  import regfile_alu_datapath_pkg::*;
#(
  parameter int DATAWIDTH     = regfile_alu_datapath_pkg::DATAWIDTH,
  parameter int SELECTIONALU  = regfile_alu_datapath_pkg::SELECTIONALU,
  parameter int SELECTIONDECO = regfile_alu_datapath_pkg::SELECTIONDECO
) (
  input  logic                     clk,
  input  logic                     highRst,
  input  logic [SELECTIONDECO-1:0] sSelDecoA,
  input  logic [SELECTIONDECO-1:0] sSelDecoB,
  input  logic [SELECTIONDECO-1:0] sSelDecoC,
  input  logic [SELECTIONALU-1:0]  sSelAlu,
  input  logic                     sLoadP0,
  input  logic                     sLoadP1,
  input  logic [DATAWIDTH-1:0]     iPort0,
  input  logic [DATAWIDTH-1:0]     iPort1,
  output logic [DATAWIDTH-1:0]     oR0,
  output logic [DATAWIDTH-1:0]     oAluOut,
  output logic                     sOverflow,
  output logic                     sCarry,
  output logic                     sNegative,
  output logic                     sZero,
  output logic                     sPar
);

  localparam int NREGS = 2 ** SELECTIONDECO;

  logic [DATAWIDTH-1:0] regs_q [NREGS];
  logic [DATAWIDTH-1:0] regs_d [NREGS];
  logic [DATAWIDTH-1:0] ra_q, ra_d;
  logic [DATAWIDTH-1:0] rb_q, rb_d;
  logic [DATAWIDTH-1:0] alu_q, alu_d;
  flags_t               flags_q, flags_d;

  // Stage 1 operand select: reads see the pre-edge bank contents
  always_comb begin
    ra_d = regs_q[sSelDecoA];
    rb_d = regs_q[sSelDecoB];
  end

  datapath_alu #(
    .DW (DATAWIDTH),
    .SW (SELECTIONALU)
  ) u_alu (
    .op_i    (sSelAlu),
    .a_i     (ra_q),
    .b_i     (rb_q),
    .res_o   (alu_d),
    .flags_o (flags_d)
  );

  // Stage 3 write-back, then port loads so an external load wins over the ALU write
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (sSelDecoC != DECO_NONE) begin
      regs_d[sSelDecoC] = alu_q;
    end
    if (sLoadP0) begin
      regs_d[REG_RP0] = iPort0;
    end
    if (sLoadP1) begin
      regs_d[REG_RP1] = iPort1;
    end
  end

  // Register bank update; reset clears every entry and suppresses the edge's write
  always_ff @(posedge clk or posedge highRst) begin
    if (highRst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Operand and result pipeline registers; reset drops anything in flight
  always_ff @(posedge clk or posedge highRst) begin
    if (highRst) begin
      ra_q    <= '0;
      rb_q    <= '0;
      alu_q   <= '0;
      flags_q <= '0;
    end else begin
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      alu_q   <= alu_d;
      flags_q <= flags_d;
    end
  end

  // Outputs are straight register taps
  always_comb begin
    oR0       = regs_q[REG_R0];
    oAluOut   = alu_q;
    sOverflow = flags_q.overflow;
    sCarry    = flags_q.carry;
    sNegative = flags_q.negative;
    sZero     = flags_q.zero;
    sPar      = flags_q.par;
  end

endmodule

// File: tb/tb_regfile_alu_datapath.sv
// Self-checking bench for regfile_alu_datapath: directed scenarios plus random traffic
// checked every cycle against an arithmetic reference model of the register bank.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_regfile_alu_datapath;

  logic       clk = 1'b0;
  logic       highRst;
  logic [2:0] sSelDecoA, sSelDecoB, sSelDecoC, sSelAlu;
  logic       sLoadP0, sLoadP1;
  logic [7:0] iPort0, iPort1;
  logic [7:0] oR0, oAluOut;
  logic       sOverflow, sCarry, sNegative, sZero, sPar;

  int checks   = 0;
  int failures = 0;

  // Reference state: register contents, captured operands, registered result and flags
  logic [7:0] m_r [8];
  logic [7:0] m_a, m_b, m_out;
  logic [4:0] m_f;   // {ovf, carry, neg, zero, par}

  always #5 clk = ~clk;

  regfile_alu_datapath dut (
    .clk       (clk),
    .highRst   (highRst),
    .sSelDecoA (sSelDecoA),
    .sSelDecoB (sSelDecoB),
    .sSelDecoC (sSelDecoC),
    .sSelAlu   (sSelAlu),
    .sLoadP0   (sLoadP0),
    .sLoadP1   (sLoadP1),
    .iPort0    (iPort0),
    .iPort1    (iPort1),
    .oR0       (oR0),
    .oAluOut   (oAluOut),
    .sOverflow (sOverflow),
    .sCarry    (sCarry),
    .sNegative (sNegative),
    .sZero     (sZero),
    .sPar      (sPar)
  );

  function automatic logic [4:0] dut_flags();
    return {sOverflow, sCarry, sNegative, sZero, sPar};
  endfunction

  function automatic int to_signed8(input int v);
    return (v > 127) ? v - 256 : v;
  endfunction

  // Reference ALU from the opcode table using integer arithmetic
  task automatic ref_alu(input int op, input int a, input int b,
                         output logic [7:0] res, output logic [4:0] f);
    int r, sr;
    bit c, v;
    r = 0; c = 0; v = 0;
    case (op)
      0: r = a;
      1: begin
        r  = a + b;
        c  = (r > 255);
        sr = to_signed8(a) + to_signed8(b);
        v  = (sr > 127) || (sr < -128);
      end
      2: begin
        r  = a - b;
        c  = (a < b);
        sr = to_signed8(a) - to_signed8(b);
        v  = (sr > 127) || (sr < -128);
      end
      3: r = a & b;
      4: begin
        r = a * 2;
        c = (a >= 128);
        v = ((a / 128) % 2) != ((a / 64) % 2);
      end
      5: begin
        r = a / 2;
        c = (a % 2) == 1;
      end
      6: r = a | b;
      default: r = a ^ b;
    endcase
    r   = r & 255;
    res = r[7:0];
    f   = {v, c, (r >= 128), (r == 0), ($countones(r) % 2 == 1)};
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_r[i] = 8'h00;
    m_a = 8'h00; m_b = 8'h00; m_out = 8'h00; m_f = 5'b0;
  endtask

  // One clock: drive inputs, advance the model across the edge, compare all outputs
  task automatic step(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c,
                      input logic [2:0] op, input logic lp0, input logic lp1,
                      input logic [7:0] p0, input logic [7:0] p1);
    logic [7:0] old_r [8];
    logic [7:0] res;
    logic [4:0] f;
    sSelDecoA = a; sSelDecoB = b; sSelDecoC = c; sSelAlu = op;
    sLoadP0 = lp0; sLoadP1 = lp1; iPort0 = p0; iPort1 = p1;
    @(posedge clk);
    for (int i = 0; i < 8; i++) old_r[i] = m_r[i];
    ref_alu(int'(op), int'(m_a), int'(m_b), res, f);
    if (c != 3'b111) m_r[c] = m_out;
    if (lp0) m_r[6] = p0;
    if (lp1) m_r[7] = p1;
    m_a = old_r[a];
    m_b = old_r[b];
    m_out = res;
    m_f = f;
    #1;
    checks++;
    if (oR0 !== m_r[0]) begin
      failures++;
      $display("FAIL cycle_oR0 got=%h want=%h at %0t", oR0, m_r[0], $time);
    end
    checks++;
    if (oAluOut !== m_out) begin
      failures++;
      $display("FAIL cycle_aluout got=%h want=%h at %0t", oAluOut, m_out, $time);
    end
    checks++;
    if (dut_flags() !== m_f) begin
      failures++;
      $display("FAIL cycle_flags got=%b want=%b at %0t", dut_flags(), m_f, $time);
    end
  endtask

  task automatic idle();
    step(3'd0, 3'd0, 3'b111, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  // Read a register back through the pipeline with a pass operation
  task automatic read_reg(input logic [2:0] idx);
    step(idx, 3'd0, 3'b111, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00);
    step(3'd0, 3'd0, 3'b111, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic test_reset();
    highRst = 1'b1;
    sSelDecoA = 3'd0; sSelDecoB = 3'd0; sSelDecoC = 3'b111; sSelAlu = 3'd0;
    sLoadP0 = 1'b0; sLoadP1 = 1'b0; iPort0 = 8'h00; iPort1 = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #3 highRst = 1'b0;
    #1;
    checks++;
    if ({oR0, oAluOut, dut_flags()} !== 21'd0) begin
      failures++;
      $display("FAIL reset_state r0=%h alu=%h flags=%b want all zero", oR0, oAluOut, dut_flags());
    end
  endtask

  task automatic test_reset_mid_op();
    step(3'd0, 3'd0, 3'b111, 3'd0, 1'b1, 1'b0, 8'h05, 8'h00);
    step(3'd6, 3'd0, 3'b111, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00);
    // Stage-2 cycle: opcode driven, reset asserted asynchronously before the edge
    sSelAlu = 3'b100;
    #2 highRst = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({oR0, oAluOut, dut_flags()} !== 21'd0) begin
      failures++;
      $display("FAIL reset_async r0=%h alu=%h flags=%b want all zero", oR0, oAluOut, dut_flags());
    end
    sSelDecoC = 3'd0;
    @(posedge clk);
    #2 highRst = 1'b0;
    step(3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00);
    checks++;
    if (oR0 !== 8'h00) begin
      failures++;
      $display("FAIL reset_no_write r0=%h want 00", oR0);
    end
    read_reg(3'd6);
    checks++;
    if (oAluOut !== 8'h00) begin
      failures++;
      $display("FAIL reset_rp0_cleared got=%h want 00", oAluOut);
    end
  endtask

  task automatic test_double();
    step(3'd0, 3'd0, 3'b111, 3'd0, 1'b1, 1'b0, 8'h41, 8'h00);
    step(3'd6, 3'd0, 3'b111, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00);
    step(3'd0, 3'd0, 3'b111, 3'b100, 1'b0, 1'b0, 8'h00, 8'h00);
    checks++;
    if (oAluOut !== 8'h82 || dut_flags() !== 5'b10100) begin
      failures++;
      $display("FAIL double_result alu=%h flags=%b want 82 10100", oAluOut, dut_flags());
    end
    step(3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00);
    checks++;
    if (oR0 !== 8'h82) begin
      failures++;
      $display("FAIL double_r0 got=%h want 82", oR0);
    end
  endtask

  task automatic test_add_carry();
    step(3'd0, 3'd0, 3'b111, 3'd0, 1'b1, 1'b1, 8'hFF, 8'h01);
    step(3'd6, 3'd7, 3'b111, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00);
    step(3'd0, 3'd0, 3'b111, 3'b001, 1'b0, 1'b0, 8'h00, 8'h00);
    checks++;
    if (oAluOut !== 8'h00 || sZero !== 1'b1 || sCarry !== 1'b1 || sOverflow !== 1'b0) begin
      failures++;
      $display("FAIL add_carry alu=%h flags=%b want 00 z=1 c=1 v=0", oAluOut, dut_flags());
    end
    step(3'd0, 3'd0, 3'd1, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic test_sub();
    step(3'd0, 3'd0, 3'b111, 3'd0, 1'b1, 1'b1, 8'h80, 8'h01);
    step(3'd6, 3'd7, 3'b111, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00);
    step(3'd0, 3'd0, 3'b111, 3'b010, 1'b0, 1'b0, 8'h00, 8'h00);
    checks++;
    if (oAluOut !== 8'h7F || sOverflow !== 1'b1 || sCarry !== 1'b0 || sPar !== 1'b1) begin
      failures++;
      $display("FAIL sub_overflow alu=%h flags=%b want 7f v=1 c=0 p=1", oAluOut, dut_flags());
    end
    step(3'd0, 3'd0, 3'b111, 3'd0, 1'b1, 1'b1, 8'h01, 8'h02);
    step(3'd6, 3'd7, 3'b111, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00);
    step(3'd0, 3'd0, 3'b111, 3'b010, 1'b0, 1'b0, 8'h00, 8'h00);
    checks++;
    if (oAluOut !== 8'hFF || sCarry !== 1'b1 || sNegative !== 1'b1) begin
      failures++;
      $display("FAIL sub_borrow alu=%h flags=%b want ff c=1 n=1", oAluOut, dut_flags());
    end
  endtask

  task automatic test_nowrite_priority();
    logic [7:0] snap [8];
    for (int i = 0; i < 8; i++) snap[i] = m_r[i];
    for (int i = 0; i < 4; i++)
      step(3'($urandom), 3'($urandom), 3'b111, 3'($urandom), 1'b0, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 8; i++) begin
      read_reg(3'(i));
      checks++;
      if (oAluOut !== snap[i]) begin
        failures++;
        $display("FAIL nowrite_r%0d got=%h want=%h", i, oAluOut, snap[i]);
      end
    end
    step(3'd0, 3'd0, 3'b111, 3'd0, 1'b1, 1'b0, 8'h11, 8'h00);
    step(3'd6, 3'd0, 3'b111, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00);
    step(3'd0, 3'd0, 3'b111, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00);
    // rAluOut now holds 11; ALU write to R6 collides with a port load of AA
    step(3'd0, 3'd0, 3'd6, 3'd0, 1'b1, 1'b0, 8'hAA, 8'h00);
    read_reg(3'd6);
    checks++;
    if (oAluOut !== 8'hAA) begin
      failures++;
      $display("FAIL load_priority r6=%h want aa", oAluOut);
    end
  endtask

  task automatic test_shift_right();
    step(3'd0, 3'd0, 3'b111, 3'd0, 1'b1, 1'b0, 8'h01, 8'h00);
    step(3'd6, 3'd0, 3'b111, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00);
    step(3'd0, 3'd0, 3'b111, 3'b101, 1'b0, 1'b0, 8'h00, 8'h00);
    checks++;
    if (oAluOut !== 8'h00 || sCarry !== 1'b1 || sZero !== 1'b1 || sOverflow !== 1'b0) begin
      failures++;
      $display("FAIL shr_edge alu=%h flags=%b want 00 c=1 z=1 v=0", oAluOut, dut_flags());
    end
  endtask

  task automatic test_back_to_back_random();
    for (int n = 0; n < 400; n++) begin
      step(3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
           8'($urandom), 8'($urandom));
    end
    for (int i = 0; i < 8; i++) begin
      read_reg(3'(i));
      checks++;
      if (oAluOut !== m_r[i]) begin
        failures++;
        $display("FAIL random_final_r%0d got=%h want=%h", i, oAluOut, m_r[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_op();
    test_double();
    test_add_carry();
    read_reg(3'd1);
    checks++;
    if (oAluOut !== 8'h00 || sZero !== 1'b1) begin
      failures++;
      $display("FAIL add_writeback_r1 got=%h z=%b want 00 z=1", oAluOut, sZero);
    end
    test_sub();
    test_nowrite_priority();
    test_shift_right();
    test_back_to_back_random();
    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
